// File: rtl/bus_if_arb_pkg.sv
// rtl/bus_if_arb_pkg.sv - Bus_if command/response encodings and master id type.
package bus_if_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'd0,
    SRESP_DVA  = 2'd1,
    SRESP_ERR  = 2'd3
  } sresp_e;

  typedef logic Master_id;

endpackage

// File: rtl/bus_if_arb_resp_order_fifo.sv
// rtl/bus_if_arb_resp_order_fifo.sv - show-ahead 1-bit FIFO holding the master id of each outstanding command.
module resp_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic data_in,
  output logic data_out,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign data_out = empty ? 1'b0 : mem[rd_ptr];

endmodule

// File: rtl/bus_if_arb.sv
// rtl/bus_if_arb.sv - two-master to one-slave Bus_if merge with in-order response routing.
// BUS_IF_ARB_FIXED_PRIO_EN: unlocked ties always go to in_0 instead of round-robin.
module bus_if_arb
  import bus_if_arb_pkg::*;
#(
  parameter int NUM_IN_FLIGHT = 4
) (
  input  logic              Clk,
  input  logic              MReset_n,

  input  logic [2:0]        in_0_MCmd,
  input  logic [ADDR_W-1:0] in_0_MAddr,
  input  logic [DATA_W-1:0] in_0_MData,
  input  logic              in_0_MDataValid,
  input  logic [BE_W-1:0]   in_0_MByteEn,
  input  logic              in_0_MRespAccept,
  output logic              in_0_SCmdAccept,
  output logic              in_0_SDataAccept,
  output logic [1:0]        in_0_SResp,
  output logic [DATA_W-1:0] in_0_SData,

  input  logic [2:0]        in_1_MCmd,
  input  logic [ADDR_W-1:0] in_1_MAddr,
  input  logic [DATA_W-1:0] in_1_MData,
  input  logic              in_1_MDataValid,
  input  logic [BE_W-1:0]   in_1_MByteEn,
  input  logic              in_1_MRespAccept,
  output logic              in_1_SCmdAccept,
  output logic              in_1_SDataAccept,
  output logic [1:0]        in_1_SResp,
  output logic [DATA_W-1:0] in_1_SData,

  output logic              out_MReset_n,
  output logic [2:0]        out_MCmd,
  output logic [ADDR_W-1:0] out_MAddr,
  output logic [DATA_W-1:0] out_MData,
  output logic              out_MDataValid,
  output logic [BE_W-1:0]   out_MByteEn,
  output logic              out_MRespAccept,
  input  logic              out_SCmdAccept,
  input  logic              out_SDataAccept,
  input  logic [1:0]        out_SResp,
  input  logic [DATA_W-1:0] out_SData
);

  logic     req_0;
  logic     req_1;
  logic     req_g;
  Master_id grant;
  Master_id tie_grant;
  Master_id idle_grant;
  logic     lock;
  Master_id lock_id;
  logic     full;
  logic     empty;
  Master_id head;
  logic     fwd_ok;
  logic     accept;
  logic     resp_ok;
  logic     pop;

  assign req_0 = (in_0_MCmd != MCMD_IDLE);
  assign req_1 = (in_1_MCmd != MCMD_IDLE);

`ifdef BUS_IF_ARB_FIXED_PRIO_EN
  assign tie_grant  = 1'b0;
  assign idle_grant = 1'b0;
`else
  Master_id rr_last;

  // Reset to in_1 so that in_0 wins the very first tie.
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      rr_last <= 1'b1;
    end else if (accept) begin
      rr_last <= grant;
    end
  end

  assign tie_grant  = ~rr_last;
  assign idle_grant = rr_last;
`endif

  always_comb begin
    grant = idle_grant;
    if (lock) begin
      grant = lock_id;
    end else if (req_0 && req_1) begin
      grant = tie_grant;
    end else if (req_0) begin
      grant = 1'b0;
    end else if (req_1) begin
      grant = 1'b1;
    end
  end

  assign req_g  = grant ? req_1 : req_0;
  assign fwd_ok = MReset_n & ~full & req_g;
  assign accept = fwd_ok & out_SCmdAccept;

  // A presented but unaccepted command pins the grant so out stays stable.
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else if (accept) begin
      lock    <= 1'b0;
    end else if (fwd_ok) begin
      lock    <= 1'b1;
      lock_id <= grant;
    end
  end

  assign out_MReset_n   = MReset_n;
  assign out_MCmd       = (MReset_n && !full) ? (grant ? in_1_MCmd : in_0_MCmd) : MCMD_IDLE;
  assign out_MAddr      = grant ? in_1_MAddr      : in_0_MAddr;
  assign out_MData      = grant ? in_1_MData      : in_0_MData;
  assign out_MDataValid = grant ? in_1_MDataValid : in_0_MDataValid;
  assign out_MByteEn    = grant ? in_1_MByteEn    : in_0_MByteEn;

  assign in_0_SCmdAccept  = fwd_ok & ~grant & out_SCmdAccept;
  assign in_1_SCmdAccept  = fwd_ok &  grant & out_SCmdAccept;
  assign in_0_SDataAccept = fwd_ok & ~grant & out_SDataAccept;
  assign in_1_SDataAccept = fwd_ok &  grant & out_SDataAccept;

  assign resp_ok         = MReset_n & ~empty;
  assign in_0_SResp      = (resp_ok && !head) ? out_SResp : SRESP_NULL;
  assign in_1_SResp      = (resp_ok &&  head) ? out_SResp : SRESP_NULL;
  assign in_0_SData      = (resp_ok && !head) ? out_SData : '0;
  assign in_1_SData      = (resp_ok &&  head) ? out_SData : '0;
  assign out_MRespAccept = resp_ok & (head ? in_1_MRespAccept : in_0_MRespAccept);
  assign pop             = out_MRespAccept & (out_SResp != SRESP_NULL);

  resp_order_fifo #(
    .DEPTH (NUM_IN_FLIGHT)
  ) u_order (
    .clk      (Clk),
    .rst_n    (MReset_n),
    .push     (accept),
    .pop      (pop),
    .data_in  (grant),
    .data_out (head),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_bus_if_arb.sv
// tb/tb_bus_if_arb.sv - scoreboard bench for bus_if_arb.
module tb_bus_if_arb;
  import bus_if_arb_pkg::*;

  logic              Clk = 1'b0;
  logic              MReset_n;
  logic [2:0]        in_0_MCmd, in_1_MCmd, out_MCmd;
  logic [ADDR_W-1:0] in_0_MAddr, in_1_MAddr, out_MAddr;
  logic [DATA_W-1:0] in_0_MData, in_1_MData, out_MData;
  logic              in_0_MDataValid, in_1_MDataValid, out_MDataValid;
  logic [BE_W-1:0]   in_0_MByteEn, in_1_MByteEn, out_MByteEn;
  logic              in_0_MRespAccept, in_1_MRespAccept, out_MRespAccept;
  logic              in_0_SCmdAccept, in_1_SCmdAccept, out_SCmdAccept;
  logic              in_0_SDataAccept, in_1_SDataAccept, out_SDataAccept;
  logic [1:0]        in_0_SResp, in_1_SResp, out_SResp;
  logic [DATA_W-1:0] in_0_SData, in_1_SData, out_SData;
  logic              out_MReset_n;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_cmd[$];
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  always #5 Clk = ~Clk;

  bus_if_arb #(.NUM_IN_FLIGHT(4)) dut (
    .Clk(Clk), .MReset_n(MReset_n),
    .in_0_MCmd(in_0_MCmd), .in_0_MAddr(in_0_MAddr), .in_0_MData(in_0_MData),
    .in_0_MDataValid(in_0_MDataValid), .in_0_MByteEn(in_0_MByteEn), .in_0_MRespAccept(in_0_MRespAccept),
    .in_0_SCmdAccept(in_0_SCmdAccept), .in_0_SDataAccept(in_0_SDataAccept),
    .in_0_SResp(in_0_SResp), .in_0_SData(in_0_SData),
    .in_1_MCmd(in_1_MCmd), .in_1_MAddr(in_1_MAddr), .in_1_MData(in_1_MData),
    .in_1_MDataValid(in_1_MDataValid), .in_1_MByteEn(in_1_MByteEn), .in_1_MRespAccept(in_1_MRespAccept),
    .in_1_SCmdAccept(in_1_SCmdAccept), .in_1_SDataAccept(in_1_SDataAccept),
    .in_1_SResp(in_1_SResp), .in_1_SData(in_1_SData),
    .out_MReset_n(out_MReset_n), .out_MCmd(out_MCmd), .out_MAddr(out_MAddr), .out_MData(out_MData),
    .out_MDataValid(out_MDataValid), .out_MByteEn(out_MByteEn), .out_MRespAccept(out_MRespAccept),
    .out_SCmdAccept(out_SCmdAccept), .out_SDataAccept(out_SDataAccept),
    .out_SResp(out_SResp), .out_SData(out_SData)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted command and every popped response is matched in order.
  always @(negedge Clk) begin
    if (MReset_n === 1'b1) begin
      if (out_MCmd != MCMD_IDLE && out_SCmdAccept) begin
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: got 0x%0h, expected none", {out_MCmd, out_MAddr});
        end else chk("cmd_order", 64'({out_MCmd, out_MAddr}), 64'(exp_cmd.pop_front()));
      end
      if (in_0_SResp == SRESP_DVA && in_0_MRespAccept) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp0_unexpected: got 0x%0h, expected none", in_0_SData);
        end else chk("resp0_data", 64'(in_0_SData), 64'(exp0.pop_front()));
      end
      if (in_1_SResp == SRESP_DVA && in_1_MRespAccept) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp1_unexpected: got 0x%0h, expected none", in_1_SData);
        end else chk("resp1_data", 64'(in_1_SData), 64'(exp1.pop_front()));
      end
    end
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_all;
    in_0_MCmd = MCMD_IDLE; in_0_MAddr = '0; in_0_MData = '0; in_0_MDataValid = 1'b0;
    in_0_MByteEn = '0; in_0_MRespAccept = 1'b1;
    in_1_MCmd = MCMD_IDLE; in_1_MAddr = '0; in_1_MData = '0; in_1_MDataValid = 1'b0;
    in_1_MByteEn = '0; in_1_MRespAccept = 1'b1;
    out_SCmdAccept = 1'b0; out_SDataAccept = 1'b0; out_SResp = SRESP_NULL; out_SData = '0;
  endtask

  task automatic issue(input logic m, input logic [2:0] cmd, input logic [31:0] a);
    if (m) begin in_1_MCmd = cmd; in_1_MAddr = a; end
    else   begin in_0_MCmd = cmd; in_0_MAddr = a; end
  endtask

  task automatic drain(input logic [31:0] d);
    out_SResp = SRESP_DVA; out_SData = d;
    step;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_mcmd"}, 64'(out_MCmd), 64'(MCMD_IDLE));
    chk({tag, "_cmd_accept0"}, 64'(in_0_SCmdAccept), 64'(0));
    chk({tag, "_sresp0"}, 64'(in_0_SResp), 64'(SRESP_NULL));
    chk({tag, "_sdata0"}, 64'(in_0_SData), 64'(0));
    chk({tag, "_resp_accept"}, 64'(out_MRespAccept), 64'(0));
    chk({tag, "_mreset_fwd"}, 64'(out_MReset_n), 64'(0));
  endtask

  task automatic single_read;
    issue(1'b0, MCMD_RD, 32'h10); out_SCmdAccept = 1'b1;
    exp_cmd.push_back({MCMD_RD, 32'h10}); exp0.push_back(32'hCAFE);
    @(negedge Clk);
    chk("s1_accept0", 64'(in_0_SCmdAccept), 64'(1));
    chk("s1_accept1", 64'(in_1_SCmdAccept), 64'(0));
    step;
    in_0_MCmd = MCMD_IDLE; out_SCmdAccept = 1'b0; out_SResp = SRESP_DVA; out_SData = 32'hCAFE;
    @(negedge Clk);
    chk("s1_in1_null", 64'(in_1_SResp), 64'(SRESP_NULL));
    chk("s1_resp_accept", 64'(out_MRespAccept), 64'(1));
    step;
    out_SResp = SRESP_NULL; out_SData = '0;
    @(negedge Clk);
    chk("s1_empty", 64'(out_MRespAccept), 64'(0));
    step;
  endtask

  initial begin
    logic        g;
    logic [31:0] a0, a1, d;
    idle_all;
    MReset_n = 1'b0;
    in_0_MCmd = MCMD_RD; out_SCmdAccept = 1'b1; out_SResp = SRESP_DVA; out_SData = 32'h1234;
    #3;
    check_reset_outputs("rst");
    step;
    idle_all;
    step;
    MReset_n = 1'b1;
    step;

    single_read;

    // Ties: rr_last is in_0 after the single read, so in_1 wins first.
    a0 = 32'h100; a1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, MCMD_RD, a0); issue(1'b1, MCMD_RD, a1); out_SCmdAccept = 1'b1;
`ifdef BUS_IF_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = (k % 2 == 0);
`endif
      d = 32'hD0 + 32'(k);
      if (g) begin exp_cmd.push_back({MCMD_RD, a1}); exp1.push_back(d); end
      else   begin exp_cmd.push_back({MCMD_RD, a0}); exp0.push_back(d); end
      @(negedge Clk);
      chk("s2_grant0", 64'(in_0_SCmdAccept), 64'(!g));
      chk("s2_grant1", 64'(in_1_SCmdAccept), 64'(g));
      step;
      if (g) a1 = a1 + 1; else a0 = a0 + 1;
    end
    in_1_MCmd = MCMD_IDLE; issue(1'b0, MCMD_RD, 32'h1FF);
    @(negedge Clk);
    chk("s2_full_mcmd", 64'(out_MCmd), 64'(MCMD_IDLE));
    chk("s2_full_accept", 64'(in_0_SCmdAccept), 64'(0));
    step;
    idle_all;
    for (int k = 0; k < 4; k++) drain(32'hD0 + 32'(k));
    out_SResp = SRESP_NULL;
    @(negedge Clk);
    chk("s2_drained", 64'(out_MRespAccept), 64'(0));
    step;

    // Locked grant held by in_1 while in_0 waits.
    issue(1'b1, MCMD_WR, 32'h300); in_1_MData = 32'h55; in_1_MDataValid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) issue(1'b0, MCMD_RD, 32'h400);
      @(negedge Clk);
      chk("s3_lock_mcmd", 64'(out_MCmd), 64'(MCMD_WR));
      chk("s3_lock_addr", 64'(out_MAddr), 64'(32'h300));
      chk("s3_lock_data", 64'(out_MData), 64'(32'h55));
      chk("s3_lock_wait0", 64'(in_0_SCmdAccept), 64'(0));
      step;
    end
    out_SCmdAccept = 1'b1; out_SDataAccept = 1'b1;
    exp_cmd.push_back({MCMD_WR, 32'h300});
    @(negedge Clk);
    chk("s3_data_accept1", 64'(in_1_SDataAccept), 64'(1));
    chk("s3_data_accept0", 64'(in_0_SDataAccept), 64'(0));
    step;
    in_1_MCmd = MCMD_IDLE; in_1_MDataValid = 1'b0; out_SDataAccept = 1'b0;
    exp_cmd.push_back({MCMD_RD, 32'h400});
    @(negedge Clk);
    chk("s3_next_grant0", 64'(in_0_SCmdAccept), 64'(1));
    step;
    idle_all;
    exp1.push_back(32'h77); exp0.push_back(32'h88);
    drain(32'h77); drain(32'h88);
    out_SResp = SRESP_NULL;

    // Ordering and response backpressure.
    issue(1'b0, MCMD_RD, 32'h500); out_SCmdAccept = 1'b1;
    exp_cmd.push_back({MCMD_RD, 32'h500}); exp0.push_back(32'hA);
    step;
    in_0_MCmd = MCMD_IDLE; issue(1'b1, MCMD_RD, 32'h600);
    exp_cmd.push_back({MCMD_RD, 32'h600}); exp1.push_back(32'hB);
    step;
    idle_all;
    in_0_MRespAccept = 1'b0; out_SResp = SRESP_DVA; out_SData = 32'hA;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk("s4_bp_accept", 64'(out_MRespAccept), 64'(0));
      chk("s4_bp_held", 64'({in_0_SResp, in_0_SData}), 64'({SRESP_DVA, 32'hA}));
      chk("s4_bp_in1_null", 64'(in_1_SResp), 64'(SRESP_NULL));
      step;
    end
    in_0_MRespAccept = 1'b1;
    step;
    out_SData = 32'hB;
    @(negedge Clk);
    chk("s4_in0_null", 64'(in_0_SResp), 64'(SRESP_NULL));
    step;
    out_SResp = SRESP_NULL; out_SData = '0;

    // Full queue: fifth command stalls until one response pops.
    out_SCmdAccept = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a0 = 32'h700 + 32'(k);
      issue(1'b0, MCMD_RD, a0);
      exp_cmd.push_back({MCMD_RD, a0});
      step;
    end
    issue(1'b0, MCMD_RD, 32'h704);
    @(negedge Clk);
    chk("s5_full_mcmd", 64'(out_MCmd), 64'(MCMD_IDLE));
    chk("s5_full_accept", 64'(in_0_SCmdAccept), 64'(0));
    step;
    out_SResp = SRESP_DVA; out_SData = 32'hE0; exp0.push_back(32'hE0);
    @(negedge Clk);
    chk("s5_pop_no_push", 64'(in_0_SCmdAccept), 64'(0));
    step;
    out_SResp = SRESP_NULL; out_SData = '0;
    exp_cmd.push_back({MCMD_RD, 32'h704});
    @(negedge Clk);
    chk("s5_fifth_accept", 64'(in_0_SCmdAccept), 64'(1));
    step;
    idle_all;
    for (int k = 1; k < 5; k++) begin
      exp0.push_back(32'hE0 + 32'(k));
      drain(32'hE0 + 32'(k));
    end
    out_SResp = SRESP_NULL;

    // Reset with two commands outstanding.
    issue(1'b0, MCMD_RD, 32'h800); out_SCmdAccept = 1'b1;
    exp_cmd.push_back({MCMD_RD, 32'h800});
    step;
    in_0_MCmd = MCMD_IDLE; issue(1'b1, MCMD_RD, 32'h900);
    exp_cmd.push_back({MCMD_RD, 32'h900});
    step;
    in_1_MCmd = MCMD_IDLE; issue(1'b0, MCMD_RD, 32'h810);
    out_SResp = SRESP_DVA; out_SData = 32'hBAD;
    #1 MReset_n = 1'b0;
    #1 check_reset_outputs("s6");
    step;
    idle_all;
    step;
    MReset_n = 1'b1;
    @(negedge Clk);
    chk("s6_queue_empty", 64'(out_MRespAccept), 64'(0));
    step;
    single_read;

    chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'(0));
    chk("resp0_queue_drained", 64'(exp0.size()), 64'(0));
    chk("resp1_queue_drained", 64'(exp1.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
